alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Front-end sequencer for the combinational ALU.
- Accepts R-type arithmetic requests (funct, two operands, tag) over a valid/ready handshake.
- Decodes funct into the `definitions::op_code` enum and drives the ALU's operand and op inputs from registers.
- Captures the ALU's result and zero flag, then returns them with the tag over a valid/ready response channel. Illegal functs are reported as errors, and operation/error counters are kept.

Parameters:
- TAG_W, 4, width of the request/response tag.
- CNT_W, 16, width of the saturating operation and error counters.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  block can accept a request.
- req_funct_i  input  6  function code: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR; all others illegal.
- req_rs_i  input  32  operand A.
- req_rt_i  input  32  operand B.
- req_tag_i  input  TAG_W  opaque tag, returned unchanged.
- alu_op_o  output  op_code  registered op to ALU (ALU_ADD/ALU_SUB/ALU_AND/ALU_OR).
- alu_rs_o  output  32  registered operand A to ALU.
- alu_rt_o  output  32  registered operand B to ALU.
- alu_result_i  input  32  ALU result (combinational from alu_*_o).
- alu_zero_i  input  1  ALU zero flag.
- rsp_valid_o  output  1  response present.
- rsp_ready_i  input  1  consumer accepts response.
- rsp_result_o  output  32  captured result.
- rsp_zero_o  output  1  captured zero flag.
- rsp_err_o  output  1  illegal funct.
- rsp_tag_o  output  TAG_W  tag of request.
- op_cnt_o  output  CNT_W  completed legal ops, saturating.
- err_cnt_o  output  CNT_W  completed illegal requests, saturating.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State IDLE.
  - req_ready_o=1, rsp_valid_o=0.
  - alu_op_o=ALU_ADD, alu_rs_o=0, alu_rt_o=0.
  - rsp_result_o=0, rsp_zero_o=0, rsp_err_o=0, rsp_tag_o=0.
  - Both counters 0.
- FSM states: IDLE, EXEC, RESP.
- req_ready_o=1 only in IDLE; rsp_valid_o=1 only in RESP. Both are registered/state-decoded, never combinational from inputs.
- IDLE, req_valid_i=1, legal funct:
  - Register the decoded op, rs and rt onto alu_*_o; register the tag.
  - Go to EXEC.
- IDLE, req_valid_i=1, illegal funct:
  - Go directly to RESP with rsp_err_o=1, rsp_result_o=0, rsp_zero_o=0, tag captured.
  - alu_*_o unchanged.
- EXEC (exactly one cycle):
  - alu_*_o are stable the whole cycle.
  - At the closing edge, capture alu_result_i into rsp_result_o and alu_zero_i into rsp_zero_o; set rsp_err_o=0.
  - Go to RESP.
- RESP:
  - Hold all rsp_* stable while rsp_ready_i=0 (no timeout).
  - On rsp_ready_i=1, go to IDLE.
  - On that same edge, increment op_cnt_o (legal) or err_cnt_o (illegal). A counter at 2^CNT_W-1 holds.
- Latency:
  - Legal: accept edge to rsp_valid_o high = 2 cycles.
  - Illegal: 1 cycle.
  - Minimum request spacing is 3 cycles (legal) or 2 cycles (illegal), with rsp_ready_i held 1.
- alu_*_o keep their last values outside EXEC. Downstream must not sample alu_result_i except in EXEC.
- Arithmetic is the ALU's 32-bit wrap-around; no overflow flag is produced here.
- Inputs req_* are don't-care when req_valid_i=0 or req_ready_o=0. No request is accepted in EXEC or RESP.
- rsp_ready_i is ignored outside RESP.
- Reset asserted mid-EXEC or mid-RESP:
  - Pending request is dropped.
  - rsp_valid_o drops immediately.
  - Counters clear.

Test Plan:
- Reset → req_ready_o=1, rsp_valid_o=0, counters 0, alu_op_o=ALU_ADD. Then ADD 0x20, rs=0x7FFFFFFF, rt=1, tag=3 → after 2 cycles rsp_result_o=0x80000000, zero=0, err=0, tag=3; op_cnt_o=1 after handshake.
- SUB rs=5, rt=5 → result 0, zero=1. SUB rs=0, rt=1 → result 0xFFFFFFFF, zero=0.
- AND 0xF0F0F0F0 & 0x0FF00FF0 → 0x00F000F0. OR 0x00000001 | 0x80000000 → 0x80000001. op_cnt_o increments per completed op.
- Illegal funct 0x2A, tag=7 → rsp_valid_o one cycle after accept, err=1, result=0, tag=7. err_cnt_o=1, op_cnt_o unchanged, alu_*_o unchanged.
- Backpressure: hold rsp_ready_i=0 for 10 cycles with req_valid_i=1 and a new funct → rsp_* stable, req_ready_o=0, second request accepted only on the cycle after the response handshake.
- Drop rst_n in EXEC → rsp_valid_o stays 0, all outputs at reset values asynchronously. After release, the next ADD 2+3 returns 5 normally.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Request/response sequencer around the combinational ALU, with the shared op_code enum.
package definitions;
   typedef enum logic [1:0] {
      ALU_ADD = 2'd0,
      ALU_SUB = 2'd1,
      ALU_AND = 2'd2,
      ALU_OR  = 2'd3
   } op_code;
endpackage

// Purpose: decode R-type funct, register ALU inputs, capture result/zero and return them with the tag.
// Latency: legal request reaches RESP 2 cycles after accept, illegal 1 cycle; one request in flight.
// Backpressure: req_ready_o only in IDLE; RESP holds rsp_* stable until rsp_ready_i.
module alu_issue_ctrl
   import definitions::*;
#(
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [5:0]       req_funct_i,
   input  logic [31:0]      req_rs_i,
   input  logic [31:0]      req_rt_i,
   input  logic [TAG_W-1:0] req_tag_i,
   output op_code           alu_op_o,
   output logic [31:0]      alu_rs_o,
   output logic [31:0]      alu_rt_o,
   input  logic [31:0]      alu_result_i,
   input  logic             alu_zero_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [31:0]      rsp_result_o,
   output logic             rsp_zero_o,
   output logic             rsp_err_o,
   output logic [TAG_W-1:0] rsp_tag_o,
   output logic [CNT_W-1:0] op_cnt_o,
   output logic [CNT_W-1:0] err_cnt_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state_q;
   state_t state_d;
   logic   funct_legal;
   op_code dec_op;

   always_comb begin
      funct_legal = 1'b1;
      dec_op      = ALU_ADD;
      case (req_funct_i)
         6'h20:   dec_op = ALU_ADD;
         6'h22:   dec_op = ALU_SUB;
         6'h24:   dec_op = ALU_AND;
         6'h25:   dec_op = ALU_OR;
         default: funct_legal = 1'b0;
      endcase
   end

   // Illegal functs skip EXEC: there is no ALU result worth waiting for.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_valid_i) state_d = funct_legal ? EXEC : RESP;
         EXEC:    state_d = RESP;
         RESP:    if (rsp_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   assign req_ready_o = (state_q == IDLE);
   assign rsp_valid_o = (state_q == RESP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_op_o     <= ALU_ADD;
         alu_rs_o     <= '0;
         alu_rt_o     <= '0;
         rsp_result_o <= '0;
         rsp_zero_o   <= 1'b0;
         rsp_err_o    <= 1'b0;
         rsp_tag_o    <= '0;
         op_cnt_o     <= '0;
         err_cnt_o    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid_i) begin
                  rsp_tag_o <= req_tag_i;
                  if (funct_legal) begin
                     alu_op_o <= dec_op;
                     alu_rs_o <= req_rs_i;
                     alu_rt_o <= req_rt_i;
                  end else begin
                     rsp_err_o    <= 1'b1;
                     rsp_result_o <= '0;
                     rsp_zero_o   <= 1'b0;
                  end
               end
            end
            EXEC: begin
               rsp_result_o <= alu_result_i;
               rsp_zero_o   <= alu_zero_i;
               rsp_err_o    <= 1'b0;
            end
            RESP: begin
               // rsp_err_o still identifies which counter this completion belongs to.
               if (rsp_ready_i) begin
                  if (rsp_err_o) begin
                     if (err_cnt_o != {CNT_W{1'b1}}) err_cnt_o <= err_cnt_o + CNT_W'(1);
                  end else begin
                     if (op_cnt_o != {CNT_W{1'b1}}) op_cnt_o <= op_cnt_o + CNT_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU closing the loop.
module tb_alu_issue_ctrl;
   import definitions::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [5:0]  req_funct = '0;
   logic [31:0] req_rs = '0;
   logic [31:0] req_rt = '0;
   logic [3:0]  req_tag = '0;
   op_code      alu_op;
   logic [31:0] alu_rs;
   logic [31:0] alu_rt;
   logic [31:0] alu_res;
   logic        alu_zero;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_result;
   logic        rsp_zero;
   logic        rsp_err;
   logic [3:0]  rsp_tag;
   logic [15:0] op_cnt;
   logic [15:0] err_cnt;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   always_comb begin
      alu_res = '0;
      case (alu_op)
         ALU_ADD: alu_res = alu_rs + alu_rt;
         ALU_SUB: alu_res = alu_rs - alu_rt;
         ALU_AND: alu_res = alu_rs & alu_rt;
         ALU_OR:  alu_res = alu_rs | alu_rt;
         default: alu_res = '0;
      endcase
   end
   assign alu_zero = (alu_res == 32'd0);

   alu_issue_ctrl #(.TAG_W(4), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_funct_i(req_funct),
      .req_rs_i(req_rs), .req_rt_i(req_rt), .req_tag_i(req_tag),
      .alu_op_o(alu_op), .alu_rs_o(alu_rs), .alu_rt_o(alu_rt),
      .alu_result_i(alu_res), .alu_zero_i(alu_zero),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
      .rsp_zero_o(rsp_zero), .rsp_err_o(rsp_err), .rsp_tag_o(rsp_tag),
      .op_cnt_o(op_cnt), .err_cnt_o(err_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] t);
      req_valid = 1'b1;
      req_funct = f;
      req_rs    = a;
      req_rt    = b;
      req_tag   = t;
      tick();
      req_valid = 1'b0;
   endtask

   // Full legal transaction with rsp_ready held high.
   task automatic legal_op(input string nm, input logic [5:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] t, input logic [31:0] res,
                           input logic zero, input logic [15:0] cnt_after);
      send(f, a, b, t);
      chk({nm, "_exec_vld"}, 64'(rsp_valid), 64'd0);
      chk({nm, "_exec_rdy"}, 64'(req_ready), 64'd0);
      chk({nm, "_exec_rs"}, 64'(alu_rs), 64'(a));
      chk({nm, "_exec_rt"}, 64'(alu_rt), 64'(b));
      tick();
      chk({nm, "_rsp_vld"}, 64'(rsp_valid), 64'd1);
      chk({nm, "_result"}, 64'(rsp_result), 64'(res));
      chk({nm, "_zero"}, 64'(rsp_zero), 64'(zero));
      chk({nm, "_err"}, 64'(rsp_err), 64'd0);
      chk({nm, "_tag"}, 64'(rsp_tag), 64'(t));
      tick();
      chk({nm, "_idle_rdy"}, 64'(req_ready), 64'd1);
      chk({nm, "_op_cnt"}, 64'(op_cnt), 64'(cnt_after));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      chk("rst_rdy", 64'(req_ready), 64'd1);
      chk("rst_vld", 64'(rsp_valid), 64'd0);
      chk("rst_op", 64'(alu_op), 64'(ALU_ADD));
      chk("rst_op_cnt", 64'(op_cnt), 64'd0);
      chk("rst_err_cnt", 64'(err_cnt), 64'd0);
      rst_n = 1'b1;
      tick();

      legal_op("add_ovf", 6'h20, 32'h7FFF_FFFF, 32'd1, 4'd3, 32'h8000_0000, 1'b0, 16'd1);
      legal_op("sub_eq", 6'h22, 32'd5, 32'd5, 4'd1, 32'd0, 1'b1, 16'd2);
      legal_op("sub_wrap", 6'h22, 32'd0, 32'd1, 4'd2, 32'hFFFF_FFFF, 1'b0, 16'd3);
      legal_op("and", 6'h24, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd5, 32'h00F0_00F0, 1'b0, 16'd4);
      legal_op("or", 6'h25, 32'h0000_0001, 32'h8000_0000, 4'd6, 32'h8000_0001, 1'b0, 16'd5);

      // Illegal funct goes straight to RESP and leaves the ALU inputs alone.
      send(6'h2A, 32'h1234, 32'h5678, 4'd7);
      chk("ill_vld", 64'(rsp_valid), 64'd1);
      chk("ill_err", 64'(rsp_err), 64'd1);
      chk("ill_result", 64'(rsp_result), 64'd0);
      chk("ill_zero", 64'(rsp_zero), 64'd0);
      chk("ill_tag", 64'(rsp_tag), 64'd7);
      chk("ill_alu_op", 64'(alu_op), 64'(ALU_OR));
      chk("ill_alu_rs", 64'(alu_rs), 64'h1);
      chk("ill_alu_rt", 64'(alu_rt), 64'h8000_0000);
      tick();
      chk("ill_err_cnt", 64'(err_cnt), 64'd1);
      chk("ill_op_cnt", 64'(op_cnt), 64'd5);

      // Backpressure with a second request waiting.
      rsp_ready = 1'b0;
      send(6'h20, 32'd10, 32'd20, 4'd4);
      tick();
      req_valid = 1'b1;
      req_funct = 6'h25;
      req_rs    = 32'h11;
      req_rt    = 32'h22;
      req_tag   = 4'd9;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_vld", 64'(rsp_valid), 64'd1);
         chk("bp_rdy", 64'(req_ready), 64'd0);
         chk("bp_result", 64'(rsp_result), 64'd30);
         chk("bp_tag", 64'(rsp_tag), 64'd4);
      end
      chk("bp_cnt_held", 64'(op_cnt), 64'd5);
      rsp_ready = 1'b1;
      tick();
      chk("bp_hs_cnt", 64'(op_cnt), 64'd6);
      chk("bp_hs_rdy", 64'(req_ready), 64'd1);
      chk("bp_not_taken", 64'(alu_op), 64'(ALU_ADD));
      tick();
      req_valid = 1'b0;
      chk("bp2_exec_op", 64'(alu_op), 64'(ALU_OR));
      chk("bp2_exec_rs", 64'(alu_rs), 64'h11);
      tick();
      chk("bp2_result", 64'(rsp_result), 64'h33);
      chk("bp2_tag", 64'(rsp_tag), 64'd9);
      tick();
      chk("bp2_cnt", 64'(op_cnt), 64'd7);

      // Asynchronous reset while in EXEC.
      send(6'h22, 32'd9, 32'd4, 4'd8);
      chk("rx_in_exec", 64'(req_ready), 64'd0);
      #1 rst_n = 1'b0;
      #1;
      chk("rx_vld", 64'(rsp_valid), 64'd0);
      chk("rx_rdy", 64'(req_ready), 64'd1);
      chk("rx_op", 64'(alu_op), 64'(ALU_ADD));
      chk("rx_rs", 64'(alu_rs), 64'd0);
      chk("rx_result", 64'(rsp_result), 64'd0);
      chk("rx_tag", 64'(rsp_tag), 64'd0);
      chk("rx_op_cnt", 64'(op_cnt), 64'd0);
      chk("rx_err_cnt", 64'(err_cnt), 64'd0);
      tick();
      chk("rx_hold_vld", 64'(rsp_valid), 64'd0);
      #3 rst_n = 1'b1;
      tick();
      legal_op("post_rst", 6'h20, 32'd2, 32'd3, 4'd1, 32'd5, 1'b0, 16'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
